// File: rtl/instr_issue_if.sv
// instr_issue_if -- instruction-memory bus and decoder issue handshake.
//   mem_rd/mem_addr/mem_rdata : word read, data valid one cycle after mem_rd
//   issue_valid/issue_ready   : decoded-field handshake towards the decoder
//   opcode..imm               : fields sliced from the held instruction
//   pc/pc_plus4               : address of the held instruction and pc+4
// master: the issue unit (instr_issue); slave: memory/decoder side.
interface instr_issue_if;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  modport master (
    output mem_rd, mem_addr, issue_valid,
    output opcode, rs, rt, rd, shamt, funct, imm, pc, pc_plus4,
    input  mem_rdata, issue_ready
  );

  modport slave (
    input  mem_rd, mem_addr, issue_valid,
    input  opcode, rs, rt, rd, shamt, funct, imm, pc, pc_plus4,
    output mem_rdata, issue_ready
  );
endinterface

// File: rtl/instr_issue.sv
// instr_issue -- fetches one instruction word, presents its decoded fields
// to the decoder, and holds them until the instruction retires.
//
// Ports:
//   clk            system clock (rising edge)
//   reset          synchronous active-high reset
//   bus            instr_issue_if.master (memory read + issue handshake)
//   retire         instruction complete (EXEC only)
//   redirect_valid next-PC override, sampled with retire
//   redirect_pc    override target, used unmodified
//   overflowflag   exception request (EXEC only, exception build)
//   divby0flag     exception request (EXEC only, exception build)
//   epc            saved exception PC
//
// Build option: define INSTR_ISSUE_EXC_EN to enable exception handling
// (overflow -> 0x100, divide-by-zero -> 0x104, epc captures pc). Without
// it both flags are ignored and epc is tied to 0.
//
// state  | meaning
// FETCH  | mem_rd asserted with mem_addr = pc
// WAIT   | read data in flight, captured into IR at end of cycle
// ISSUE  | issue_valid asserted, waiting for issue_ready
// EXEC   | fields held, waiting for retire / exception
module instr_issue (
  input  logic        clk,
  input  logic        reset,
  instr_issue_if.master bus,
  input  logic        retire,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        overflowflag,
  input  logic        divby0flag,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_EXEC  = 2'd3
  } state_e;

  localparam logic [31:0] OVF_VECTOR   = 32'h0000_0100;
  localparam logic [31:0] DIVBY0_VECTOR = 32'h0000_0104;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_plus4;

`ifdef INSTR_ISSUE_EXC_EN
  logic [31:0] epc_q, epc_d;
`else
  logic        unused_flags;
  assign unused_flags = overflowflag ^ divby0flag;
`endif

  assign pc_plus4 = pc_q + 32'd4;  // wraps mod 2^32

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
`ifdef INSTR_ISSUE_EXC_EN
    epc_d           = epc_q;
`endif
    bus.mem_rd      = 1'b0;
    bus.issue_valid = 1'b0;

    case (state_q)
      ST_FETCH: begin
        bus.mem_rd = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        ir_d    = bus.mem_rdata;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.issue_valid = 1'b1;
        if (bus.issue_ready) state_d = ST_EXEC;
      end
      ST_EXEC: begin
`ifdef INSTR_ISSUE_EXC_EN
        // Exceptions outrank retire; overflow outranks divide-by-zero.
        if (overflowflag) begin
          epc_d   = pc_q;
          pc_d    = OVF_VECTOR;
          state_d = ST_FETCH;
        end else if (divby0flag) begin
          epc_d   = pc_q;
          pc_d    = DIVBY0_VECTOR;
          state_d = ST_FETCH;
        end else if (retire) begin
          pc_d    = redirect_valid ? redirect_pc : pc_plus4;
          state_d = ST_FETCH;
        end
`else
        if (retire) begin
          pc_d    = redirect_valid ? redirect_pc : pc_plus4;
          state_d = ST_FETCH;
        end
`endif
      end
      default: state_d = ST_FETCH;
    endcase

    // Strobes are suppressed combinationally during the reset cycle itself.
    if (reset) begin
      bus.mem_rd      = 1'b0;
      bus.issue_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= 32'h0;
      ir_q    <= 32'h0;
`ifdef INSTR_ISSUE_EXC_EN
      epc_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef INSTR_ISSUE_EXC_EN
      epc_q   <= epc_d;
`endif
    end
  end

`ifdef INSTR_ISSUE_EXC_EN
  assign epc = epc_q;
`else
  assign epc = 32'h0;
`endif

  assign bus.mem_addr = pc_q;
  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.opcode   = ir_q[31:26];
  assign bus.rs       = ir_q[25:21];
  assign bus.rt       = ir_q[20:16];
  assign bus.rd       = ir_q[15:11];
  assign bus.shamt    = ir_q[10:6];
  assign bus.funct    = ir_q[5:0];
  assign bus.imm      = ir_q[15:0];

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;
  logic        clk = 1'b0;
  logic        reset;
  logic        retire;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        overflowflag;
  logic        divby0flag;
  logic [31:0] epc;
  int          total = 0;
  int          bad = 0;

  instr_issue_if ifc ();

  instr_issue dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (ifc.master),
    .retire         (retire),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .overflowflag   (overflowflag),
    .divby0flag     (divby0flag),
    .epc            (epc)
  );

  always #5 clk = ~clk;

  // Instruction memory: fixed words at the addresses the tests use,
  // an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h012A_4020;  // add $8,$9,$10
      32'h0000_0040: mem_word = 32'h8D0A_0004;  // lw  $10,4($8)
      default:       mem_word = ~a;
    endcase
  endfunction

  // Data is valid only in the cycle after mem_rd; garbage otherwise so a
  // capture at the wrong edge is visible.
  always @(posedge clk) begin
    if (ifc.mem_rd) ifc.mem_rdata <= mem_word(ifc.mem_addr);
    else            ifc.mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // From FETCH (at a negedge) through WAIT and ISSUE into EXEC.
  task automatic advance_to_exec;
    ifc.issue_ready = 1'b1;
    tick(); tick(); tick();
    ifc.issue_ready = 1'b0;
    #1;
  endtask

  task automatic retire_to(input logic redir, input logic [31:0] target);
    retire = 1'b1; redirect_valid = redir; redirect_pc = target;
    tick();
    retire = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    total++; if (ifc.mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b want=0", ifc.mem_rd); end
    total++; if (ifc.issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%b want=0", ifc.issue_valid); end
    total++; if (ifc.pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", ifc.pc); end
    total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h want=0", epc); end
    total++; if (ifc.opcode !== 6'd0 || ifc.funct !== 6'd0) begin bad++; $display("FAIL reset_ir got=%h/%h want=0/0", ifc.opcode, ifc.funct); end
  endtask

  task automatic test_fetch_issue;
    reset = 1'b0;
    #1;
    total++; if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 32'h0) begin bad++; $display("FAIL c0_fetch got rd=%b addr=%h want rd=1 addr=0", ifc.mem_rd, ifc.mem_addr); end
    total++; if (ifc.issue_valid !== 1'b0) begin bad++; $display("FAIL c0_issue_valid got=%b want=0", ifc.issue_valid); end
    tick();
    total++; if (ifc.mem_rd !== 1'b0 || ifc.issue_valid !== 1'b0) begin bad++; $display("FAIL c1_wait got rd=%b iv=%b want 0 0", ifc.mem_rd, ifc.issue_valid); end
    tick();
    total++; if (ifc.issue_valid !== 1'b1) begin bad++; $display("FAIL c2_issue_valid got=%b want=1", ifc.issue_valid); end
    total++; if ({ifc.opcode, ifc.rs, ifc.rt, ifc.rd, ifc.shamt, ifc.funct} !== {6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'd32})
      begin bad++; $display("FAIL c2_fields got op=%0d rs=%0d rt=%0d rd=%0d sh=%0d fn=%0d want 0 9 10 8 0 32", ifc.opcode, ifc.rs, ifc.rt, ifc.rd, ifc.shamt, ifc.funct); end
    total++; if (ifc.imm !== 16'h4020) begin bad++; $display("FAIL c2_imm got=%h want=4020", ifc.imm); end
    total++; if (ifc.pc !== 32'h0 || ifc.pc_plus4 !== 32'h4) begin bad++; $display("FAIL c2_pc got=%h/%h want=0/4", ifc.pc, ifc.pc_plus4); end
  endtask

  task automatic test_stall;
    // retire/redirect must be ignored while waiting in ISSUE.
    retire = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0999;
    for (int i = 0; i < 5; i++) begin
      total++; if (ifc.issue_valid !== 1'b1 || ifc.mem_rd !== 1'b0) begin bad++; $display("FAIL stall_%0d_strobes got iv=%b rd=%b want 1 0", i, ifc.issue_valid, ifc.mem_rd); end
      total++; if ({ifc.opcode, ifc.rs, ifc.rt, ifc.rd, ifc.funct} !== {6'd0, 5'd9, 5'd10, 5'd8, 6'd32})
        begin bad++; $display("FAIL stall_%0d_fields got op=%0d rs=%0d rt=%0d rd=%0d fn=%0d", i, ifc.opcode, ifc.rs, ifc.rt, ifc.rd, ifc.funct); end
      tick();
    end
    retire = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    ifc.issue_ready = 1'b1;
    tick();
    ifc.issue_ready = 1'b0;
    #1;
    total++; if (ifc.issue_valid !== 1'b0 || ifc.mem_rd !== 1'b0) begin bad++; $display("FAIL exec_entry got iv=%b rd=%b want 0 0", ifc.issue_valid, ifc.mem_rd); end
    total++; if (ifc.pc !== 32'h0) begin bad++; $display("FAIL stall_retire_ignored got pc=%h want=0", ifc.pc); end
  endtask

  task automatic test_exec_hold;
`ifndef INSTR_ISSUE_EXC_EN
    overflowflag = 1'b1; divby0flag = 1'b1;
`endif
    tick(); tick();
    overflowflag = 1'b0; divby0flag = 1'b0;
    #1;
    total++; if (ifc.mem_rd !== 1'b0 || ifc.issue_valid !== 1'b0) begin bad++; $display("FAIL exec_hold_strobes got rd=%b iv=%b want 0 0", ifc.mem_rd, ifc.issue_valid); end
    total++; if (ifc.pc !== 32'h0 || ifc.funct !== 6'd32 || epc !== 32'h0) begin bad++; $display("FAIL exec_hold_state got pc=%h fn=%0d epc=%h want 0 32 0", ifc.pc, ifc.funct, epc); end
  endtask

  task automatic test_redirect;
    retire_to(1'b1, 32'h0000_0040);
    total++; if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 32'h40) begin bad++; $display("FAIL redirect_fetch got rd=%b addr=%h want 1 40", ifc.mem_rd, ifc.mem_addr); end
    advance_to_exec();
    total++; if (ifc.opcode !== 6'h23 || ifc.rs !== 5'd8 || ifc.rt !== 5'd10 || ifc.imm !== 16'h0004)
      begin bad++; $display("FAIL lw_fields got op=%h rs=%0d rt=%0d imm=%h want 23 8 10 0004", ifc.opcode, ifc.rs, ifc.rt, ifc.imm); end
    total++; if (ifc.pc !== 32'h40 || ifc.pc_plus4 !== 32'h44) begin bad++; $display("FAIL pc_40 got=%h/%h want=40/44", ifc.pc, ifc.pc_plus4); end
    retire_to(1'b0, 32'h0000_0999);
    total++; if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 32'h44) begin bad++; $display("FAIL seq_fetch got rd=%b addr=%h want 1 44", ifc.mem_rd, ifc.mem_addr); end
  endtask

  task automatic test_wrap;
    advance_to_exec();
    retire_to(1'b1, 32'hFFFF_FFFC);
    total++; if (ifc.mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fetch got=%h want=fffffffc", ifc.mem_addr); end
    advance_to_exec();
    total++; if (ifc.pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc_plus4 got=%h want=0", ifc.pc_plus4); end
    total++; if (ifc.imm !== 16'h0003) begin bad++; $display("FAIL wrap_ir got imm=%h want=0003", ifc.imm); end
    retire_to(1'b0, 32'h0);
    total++; if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got rd=%b addr=%h want 1 0", ifc.mem_rd, ifc.mem_addr); end
  endtask

  task automatic test_exceptions;
    advance_to_exec();
    retire_to(1'b1, 32'h0000_0020);
    advance_to_exec();
    total++; if (ifc.pc !== 32'h20) begin bad++; $display("FAIL exc_setup_pc got=%h want=20", ifc.pc); end
`ifdef INSTR_ISSUE_EXC_EN
    overflowflag = 1'b1; divby0flag = 1'b1;
    retire_to(1'b1, 32'h0000_0300);
    overflowflag = 1'b0; divby0flag = 1'b0;
    total++; if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 32'h100) begin bad++; $display("FAIL exc_ovf_vector got rd=%b addr=%h want 1 100", ifc.mem_rd, ifc.mem_addr); end
    total++; if (epc !== 32'h20) begin bad++; $display("FAIL exc_ovf_epc got=%h want=20", epc); end
    advance_to_exec();
    divby0flag = 1'b1;
    retire_to(1'b0, 32'h0);
    divby0flag = 1'b0;
    total++; if (ifc.mem_addr !== 32'h104) begin bad++; $display("FAIL exc_div_vector got=%h want=104", ifc.mem_addr); end
    total++; if (epc !== 32'h100) begin bad++; $display("FAIL exc_div_epc got=%h want=100", epc); end
`else
    overflowflag = 1'b1; divby0flag = 1'b1;
    tick(); tick();
    #1;
    total++; if (ifc.mem_rd !== 1'b0 || ifc.pc !== 32'h20 || epc !== 32'h0) begin bad++; $display("FAIL flags_ignored got rd=%b pc=%h epc=%h want 0 20 0", ifc.mem_rd, ifc.pc, epc); end
    retire_to(1'b0, 32'h0);
    overflowflag = 1'b0; divby0flag = 1'b0;
    total++; if (ifc.mem_addr !== 32'h24 || epc !== 32'h0) begin bad++; $display("FAIL flags_retire got addr=%h epc=%h want 24 0", ifc.mem_addr, epc); end
`endif
  endtask

  task automatic test_reset_mid;
    advance_to_exec();
    retire_to(1'b1, 32'h0000_0080);
    ifc.issue_ready = 1'b0;
    tick(); tick();
    #1;
    total++; if (ifc.issue_valid !== 1'b1 || ifc.pc !== 32'h80) begin bad++; $display("FAIL mid_setup got iv=%b pc=%h want 1 80", ifc.issue_valid, ifc.pc); end
    reset = 1'b1; retire = 1'b1; overflowflag = 1'b1;
    #1;
    total++; if (ifc.issue_valid !== 1'b0 || ifc.mem_rd !== 1'b0) begin bad++; $display("FAIL mid_reset_strobes got iv=%b rd=%b want 0 0", ifc.issue_valid, ifc.mem_rd); end
    tick();
    reset = 1'b0; retire = 1'b0; overflowflag = 1'b0;
    #1;
    total++; if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 32'h0) begin bad++; $display("FAIL mid_refetch got rd=%b addr=%h want 1 0", ifc.mem_rd, ifc.mem_addr); end
    total++; if (epc !== 32'h0) begin bad++; $display("FAIL mid_epc got=%h want=0", epc); end
    tick(); tick();
    #1;
    total++; if (ifc.issue_valid !== 1'b1 || ifc.funct !== 6'd32 || ifc.rs !== 5'd9) begin bad++; $display("FAIL mid_reissue got iv=%b fn=%0d rs=%0d want 1 32 9", ifc.issue_valid, ifc.funct, ifc.rs); end
  endtask

  initial begin
    reset = 1'b1; retire = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    overflowflag = 1'b0; divby0flag = 1'b0; ifc.issue_ready = 1'b0;
    test_reset();
    test_fetch_issue();
    test_stall();
    test_exec_hold();
    test_redirect();
    test_wrap();
    test_exceptions();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end
endmodule
